uart_rx_ctrl: RTL and testbench

Controller for the UART receive path. It generates the 16x-oversample baud_timer tick that drives the receiver and captures each completed byte on the receiver's rx_data_received pulse into a show-ahead FIFO. It also reports FIFO occupancy, a sticky overrun flag, and a character-timeout indication to the host-side logic.

---
 rtl/uart_rx_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller.
// Generates the 16x oversample tick for the receiver and queues each received
// byte in a small show-ahead FIFO. It also reports occupancy, a sticky overrun
// flag and a character timeout to the host side.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_DISABLED | baud counter parked at 0, no ticks, receiver pulses ignored
// ST_RUN      | baud generator running, received bytes captured into FIFO
//
// The FIFO stays readable and poppable in both states.

module uart_rx_ctrl #(
    parameter int DATA_LENGTH   = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int DIV_WIDTH     = 16,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               enable_i,
    input  logic [DIV_WIDTH-1:0]               divisor_i,
    input  logic                               flush_i,
    output logic                               baud_timer_o,
    input  logic                               rx_data_received_i,
    input  logic [DATA_LENGTH-1:0]             rx_data_i,
    input  logic                               rd_en_i,
    output logic [DATA_LENGTH-1:0]             rd_data_o,
    output logic                               rd_valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o,
    output logic                               overrun_o,
    input  logic                               clear_overrun_i,
    output logic                               rx_timeout_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_TICKS);

    typedef enum logic {
        ST_DISABLED = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    state_t                   state_q;
    logic                     run_q;

    logic [DIV_WIDTH-1:0]     baud_cnt_q;
    logic [DIV_WIDTH-1:0]     baud_cnt_d;
    logic [DIV_WIDTH-1:0]     div_m1;
    logic                     baud_tick;

    logic [DATA_LENGTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_d;
    logic [CNT_W-1:0]         count_q;
    logic [CNT_W-1:0]         count_d;

    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     push_req;
    logic                     push;
    logic                     pop;
    logic                     ovr_set;

    logic                     overrun_q;
    logic                     overrun_d;

    logic [TO_W-1:0]          to_cnt_q;
    logic [TO_W-1:0]          to_cnt_d;
    logic                     rx_timeout_q;
    logic                     rx_timeout_d;

    // Enable sequencing: run_q is the registered "captures allowed" output.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_DISABLED;
            run_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    if (enable_i) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable_i) begin
                        state_q <= ST_DISABLED;
                        run_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_DISABLED;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    // Baud generator: compare against the live divisor so a shrinking divisor
    // that leaves the counter past its new terminal value ticks immediately.
    always_comb begin
        div_m1     = (divisor_i == '0) ? '0 : divisor_i - DIV_WIDTH'(1);
        baud_tick  = run_q && (baud_cnt_q >= div_m1);
        baud_cnt_d = '0;
        if (run_q && !baud_tick) begin
            baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
    end

    // Baud counter register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_d_assign: baud_cnt_q <= baud_cnt_d;
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so a push to a full
    // FIFO alongside a pop is accepted rather than flagged as overrun.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_FULL);
        pop        = rd_en_i && !fifo_empty;
        push_req   = rx_data_received_i && run_q;
        push       = push_req && (!fifo_full || pop);
        ovr_set    = push_req && fifo_full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads 0 out of reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    // Overrun and timeout next-state; a set beats a same-cycle clear.
    always_comb begin
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clear_overrun_i) begin
            overrun_d = 1'b0;
        end

        to_cnt_d = to_cnt_q;
        if (flush_i || push || pop || fifo_empty) begin
            to_cnt_d = '0;
        end else if (baud_tick && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        rx_timeout_d = (to_cnt_d == TO_MAX) && (count_d != '0);
    end

    // Status registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            overrun_q    <= 1'b0;
            to_cnt_q     <= '0;
            rx_timeout_q <= 1'b0;
        end else begin
            overrun_q    <= overrun_d;
            to_cnt_q     <= to_cnt_d;
            rx_timeout_q <= rx_timeout_d;
        end
    end

    assign baud_timer_o = baud_tick;
    assign rd_data_o    = mem_q[rd_ptr_q];
    assign rd_valid_o   = !fifo_empty;
    assign fifo_count_o = count_q;
    assign overrun_o    = overrun_q;
    assign rx_timeout_o = rx_timeout_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the controller.

module tb_uart_rx_ctrl;

    localparam int DL    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int TO    = 640;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          enable_i;
    logic [DW-1:0] divisor_i;
    logic          flush_i;
    logic          baud_timer_o;
    logic          rx_data_received_i;
    logic [DL-1:0] rx_data_i;
    logic          rd_en_i;
    logic [DL-1:0] rd_data_o;
    logic          rd_valid_o;
    logic [CW-1:0] fifo_count_o;
    logic          overrun_o;
    logic          clear_overrun_i;
    logic          rx_timeout_o;

    uart_rx_ctrl #(
        .DATA_LENGTH(DL), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW), .TIMEOUT_TICKS(TO)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
        .divisor_i(divisor_i), .flush_i(flush_i), .baud_timer_o(baud_timer_o),
        .rx_data_received_i(rx_data_received_i), .rx_data_i(rx_data_i),
        .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .fifo_count_o(fifo_count_o), .overrun_o(overrun_o),
        .clear_overrun_i(clear_overrun_i), .rx_timeout_o(rx_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    bit            m_run;
    int            m_cnt;
    logic [DL-1:0] m_q[$];
    bit            m_ovr;
    int            m_to;
    bit            m_tout;
    bit            obs_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit m_tick();
        int d;
        d = (divisor_i == 0) ? 1 : int'(divisor_i);
        return m_run && (m_cnt >= d - 1);
    endfunction

    task automatic m_reset();
        m_run = 0; m_cnt = 0; m_q.delete(); m_ovr = 0; m_to = 0; m_tout = 0;
    endtask

    // Advance the model across one clock edge using the inputs held this cycle.
    task automatic m_edge();
        bit tk, pop, preq, full, push, oset;
        tk   = m_tick();
        pop  = rd_en_i && (m_q.size() > 0);
        preq = rx_data_received_i && m_run;
        full = (m_q.size() == DEPTH);
        push = preq && (!full || pop);
        oset = preq && full && !pop;
        if (flush_i) m_q.delete();
        else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(rx_data_i);
        end
        if (oset) m_ovr = 1;
        else if (clear_overrun_i) m_ovr = 0;
        if (flush_i || push || pop || m_q.size() == 0 || (pop ? 0 : 0)) m_to = 0;
        else if (tk && m_to < TO) m_to++;
        if (m_q.size() == 0) m_to = 0;
        m_cnt  = m_run ? (tk ? 0 : m_cnt + 1) : 0;
        m_run  = enable_i;
        m_tout = (m_to == TO) && (m_q.size() > 0);
    endtask

    task automatic check_all();
        obs_tick = baud_timer_o;
        chk("baud_timer", baud_timer_o, m_tick());
        chk("rd_valid", rd_valid_o, m_q.size() > 0);
        chk("fifo_count", fifo_count_o, m_q.size());
        chk("overrun", overrun_o, m_ovr);
        chk("rx_timeout", rx_timeout_o, m_tout);
        if (m_q.size() > 0) chk("rd_data", rd_data_o, m_q[0]);
    endtask

    // Called with inputs set at posedge+1; returns at the next posedge+1.
    task automatic step();
        #1 check_all();
        @(posedge clk_i);
        m_edge();
        #1;
    endtask

    task automatic idle_in();
        rx_data_received_i = 0; rd_en_i = 0; flush_i = 0; clear_overrun_i = 0;
    endtask

    task automatic push_byte(input logic [DL-1:0] b);
        rx_data_received_i = 1; rx_data_i = b; step(); rx_data_received_i = 0;
    endtask

    task automatic pop_byte();
        rd_en_i = 1; step(); rd_en_i = 0;
    endtask

    int ticks;
    logic [DL-1:0] exp_b;

    initial begin
        reset_n_i = 0; enable_i = 0; divisor_i = 4; idle_in(); rx_data_i = 0;
        m_reset();
        #12;
        chk("rst_baud", baud_timer_o, 0);
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_count", fifo_count_o, 0);
        chk("rst_data", rd_data_o, 0);
        chk("rst_ovr", overrun_o, 0);
        chk("rst_tout", rx_timeout_o, 0);
        @(posedge clk_i); #1 reset_n_i = 1;

        // baud tick, divisor 4
        enable_i = 1; step(); step();
        ticks = 0;
        for (int i = 0; i < 40; i++) begin step(); ticks += obs_tick; end
        chk("ticks_div4", ticks, 10);
        divisor_i = 0; ticks = 0;
        for (int i = 0; i < 10; i++) begin step(); ticks += obs_tick; end
        chk("ticks_div0", ticks, 10);
        enable_i = 0; step(); step(); ticks = 0;
        for (int i = 0; i < 10; i++) begin step(); ticks += obs_tick; end
        chk("ticks_off", ticks, 0);
        divisor_i = 3; enable_i = 1; step();

        // capture and read
        push_byte(8'hA5); push_byte(8'h3C);
        chk("cap_count", fifo_count_o, 2);
        chk("cap_head", rd_data_o, 8'hA5);
        pop_byte();
        chk("pop1_head", rd_data_o, 8'h3C);
        chk("pop1_count", fifo_count_o, 1);
        pop_byte();
        chk("pop2_valid", rd_valid_o, 0);

        // full and overrun
        for (int i = 1; i <= 5; i++) push_byte(DL'(i));
        chk("full_count", fifo_count_o, DEPTH);
        chk("full_ovr", overrun_o, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("full_rd", rd_data_o, i);
            pop_byte();
        end
        clear_overrun_i = 1; step(); clear_overrun_i = 0;
        chk("ovr_clr", overrun_o, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 4; i++) push_byte(DL'(8'h10 + i));
        rd_en_i = 1; push_byte(8'h77); rd_en_i = 0;
        chk("pp_count", fifo_count_o, DEPTH);
        chk("pp_ovr", overrun_o, 0);
        for (int i = 0; i < 4; i++) begin
            exp_b = (i == 3) ? 8'h77 : DL'(8'h11 + i);
            chk("pp_rd", rd_data_o, exp_b);
            pop_byte();
        end

        // timeout with a tick every clock
        divisor_i = 1;
        push_byte(8'h5A);
        for (int i = 0; i < TO - 1; i++) step();
        chk("to_early", rx_timeout_o, 0);
        step();
        chk("to_hit", rx_timeout_o, 1);
        pop_byte();
        chk("to_popclr", rx_timeout_o, 0);
        for (int i = 0; i < 700; i++) step();
        chk("to_empty", rx_timeout_o, 0);

        // flush keeps overrun
        for (int i = 0; i < 5; i++) push_byte(DL'(8'h20 + i));
        pop_byte();
        chk("fl_pre", fifo_count_o, 3);
        flush_i = 1; step(); flush_i = 0;
        chk("fl_count", fifo_count_o, 0);
        chk("fl_valid", rd_valid_o, 0);
        chk("fl_ovr", overrun_o, 1);

        // async reset mid-burst
        push_byte(8'h81); push_byte(8'h82);
        rx_data_received_i = 1; rx_data_i = 8'h83;
        reset_n_i = 0;
        #1;
        chk("ar_valid", rd_valid_o, 0);
        chk("ar_count", fifo_count_o, 0);
        chk("ar_data", rd_data_o, 0);
        chk("ar_ovr", overrun_o, 0);
        chk("ar_baud", baud_timer_o, 0);
        m_reset();
        idle_in();
        @(posedge clk_i); #1 reset_n_i = 1;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            enable_i           = ($urandom_range(0, 99) < 95);
            if ($urandom_range(0, 49) == 0) divisor_i = DW'($urandom_range(0, 6));
            rx_data_received_i = ($urandom_range(0, 99) < 35);
            rx_data_i          = DL'($urandom_range(0, 255));
            rd_en_i            = ($urandom_range(0, 99) < 30);
            flush_i            = ($urandom_range(0, 99) < 2);
            clear_overrun_i    = ($urandom_range(0, 99) < 5);
            step();
        end
        idle_in();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
